slice_extend_arbiter: RTL
=========================

Name: slice_extend_arbiter

Overview:
Shares one bit-field extract / sign-or-zero-extend datapath between two requesters. Each requester presents a source word plus field descriptor: lsb offset, length and signedness. A round-robin arbiter grants one request per cycle into a registered result stage. The result stage has valid/ready flow control toward a single consumer. The block sits in front of the width-conversion logic that turns narrow slices into sign- or zero-extended wide values.

Parameters:
WIDTH, 8, source word width in bits (>=2)
OUT_WIDTH, 8, result width in bits (>=1)
LSB_W, $clog2(WIDTH), width of lsb offset field
LEN_W, $clog2(WIDTH)+1, width of length field (can encode WIDTH)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a request
req0_ready  output  1  requester 0 request accepted this cycle
req0_data  input  WIDTH  requester 0 source word
req0_lsb  input  LSB_W  requester 0 field lsb position
req0_len  input  LEN_W  requester 0 field length in bits
req0_signed  input  1  1 = sign-extend, 0 = zero-extend
req1_valid / req1_ready / req1_data / req1_lsb / req1_len / req1_signed  same as requester 0, for requester 1
res_valid  output  1  result register holds a result
res_ready  input  1  consumer takes result
res_data  output  OUT_WIDTH  extracted and extended field
res_src  output  1  index of requester that produced res_data
res_err  output  1  descriptor was illegal

Behaviour:
- Reset (rst_n low, asynchronous): res_valid=0, res_data=0, res_src=0, res_err=0, priority pointer=0 (requester 0 preferred). req*_ready are combinational and therefore 0 while res_valid is 0 and no request is valid.
- Accept condition: can_load = !res_valid || res_ready.
- Arbitration (combinational, only when can_load):
  - If only one requester is valid, grant it.
  - If both are valid, grant the one the pointer selects.
  - reqN_ready = grant to N.
  - No grant when !can_load; both readies are 0 in that case.
- Pointer update:
  - On any grant to N, pointer <= 1-N; the loser is preferred next.
  - No grant, no change.
- Latency: granted request appears on res_* the following cycle with res_valid=1.
- Hold: while res_valid && !res_ready, res_data, res_src and res_err are stable.
- Drain: on res_ready && res_valid with no new grant, res_valid <= 0; res_data holds its last value.
- Throughput: simultaneous res_ready and a grant reloads the register in the same cycle; one result per cycle is sustained.
- Extraction: field = (data >> lsb) & ((1<<len)-1).
  - Extension: if signed and bit len-1 of the field is 1, bits len..OUT_WIDTH-1 are filled with 1; otherwise they are filled with 0.
  - Truncation: if len > OUT_WIDTH, res_data = low OUT_WIDTH bits of the field. res_err is not set for this case.
  - len == WIDTH, lsb == 0: whole word passes through with the same extend/truncate rules.
- Illegal descriptor: len == 0 or lsb+len > WIDTH, evaluated in LEN_W+1 bits with no wrap.
  - The request is still accepted and still consumes the grant.
  - Result: res_err=1 and res_data=0.
- Arithmetic: all shift/mask math is done at WIDTH+1 bits so that len == WIDTH does not overflow the mask.
- Inputs ignored when not granted; a requester may change its inputs while not ready.

Test Plan:
- Reset state: hold rst_n=0 with req0_valid=1 -> res_valid=0, res_data=0x00, req0_ready=0. Deassert rst_n -> req0_ready=1 in that cycle, res_valid=1 one cycle later.
- Sign extend: req0 data=0xB4, lsb=2, len=4, signed=1 -> res_data=0xFD, res_src=0, res_err=0. Same descriptor with signed=0 -> res_data=0x0D.
- Round-robin: both requesters valid continuously, res_ready=1 -> grants alternate 0,1,0,1 starting with 0 after reset. res_src sequence is 0,1,0,1 and one result is produced per cycle.
- Back-pressure: res_ready=0 for 3 cycles with both requesters valid -> both readies 0 and res_* stable. Raise res_ready -> the next grant goes to the requester not last served.
- Illegal descriptor: req1 lsb=6, len=3 -> res_err=1, res_data=0x00, res_src=1, pointer moves to 0. Also len=0 -> res_err=1.
- Full width and async reset: lsb=0, len=8, data=0x80, signed=1, OUT_WIDTH=8 -> res_data=0x80, res_err=0. Then assert rst_n mid-stall while res_valid=1 -> res_valid drops to 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/slice_extend_arbiter.sv
// slice_extend_arbiter: two-requester round-robin bit-field extract and sign/zero extend with a registered valid/ready result
module slice_extend_arbiter #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 8,
  parameter int LSB_W     = $clog2(WIDTH),
  parameter int LEN_W     = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_data,
  input  logic [LSB_W-1:0]     req0_lsb,
  input  logic [LEN_W-1:0]     req0_len,
  input  logic                 req0_signed,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_data,
  input  logic [LSB_W-1:0]     req1_lsb,
  input  logic [LEN_W-1:0]     req1_len,
  input  logic                 req1_signed,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [OUT_WIDTH-1:0] res_data,
  output logic                 res_src,
  output logic                 res_err
);
  localparam int EW = (OUT_WIDTH > WIDTH + 1) ? OUT_WIDTH : WIDTH + 1;
  localparam logic [WIDTH:0] ONE = 1;
  logic ptr, can_load, gnt0, gnt1, sgn, neg, illegal;
  logic [WIDTH-1:0] data;
  logic [LSB_W-1:0] lsb;
  logic [LEN_W-1:0] len;
  logic [WIDTH:0] shifted, mask, field, top;
  logic [EW-1:0] ext;
  logic [OUT_WIDTH-1:0] next_data;
  // Grant one requester per cycle; the pointer breaks ties, readies stay low during reset
  always_comb begin
    can_load   = !res_valid || res_ready;
    gnt0       = rst_n && can_load && req0_valid && (!req1_valid || !ptr);
    gnt1       = rst_n && can_load && req1_valid && (!req0_valid || ptr);
    req0_ready = gnt0;
    req1_ready = gnt1;
  end
  // Extract the granted field at WIDTH+1 bits, then extend or truncate to OUT_WIDTH
  always_comb begin
    data      = gnt1 ? req1_data : req0_data;
    lsb       = gnt1 ? req1_lsb : req0_lsb;
    len       = gnt1 ? req1_len : req0_len;
    sgn       = gnt1 ? req1_signed : req0_signed;
    illegal   = (len == '0) || ((LEN_W+1)'(lsb) + (LEN_W+1)'(len) > (LEN_W+1)'(WIDTH));
    shifted   = {1'b0, data} >> lsb;
    mask      = (ONE << len) - ONE;
    field     = shifted & mask;
    top       = mask ^ (mask >> 1);
    neg       = sgn && |(field & top);
    ext       = EW'(field) | (neg ? ~EW'(mask) : '0);
    next_data = illegal ? '0 : OUT_WIDTH'(ext);
  end
  // Result register: load on grant, drain on consumer take, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_src   <= 1'b0;
      res_err   <= 1'b0;
      ptr       <= 1'b0;
    end else if (gnt0 || gnt1) begin
      res_valid <= 1'b1;
      res_data  <= next_data;
      res_src   <= gnt1;
      res_err   <= illegal;
      ptr       <= gnt0;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end
endmodule
